pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, legal 1..7: cycles o_flush_id is held after a taken branch.
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_id_rs1, i_id_rs2  in  5 each  ID-stage source registers.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
- i_ex_rd  in  5  EX-stage destination.
- i_ex_mem_read  in  1  EX instruction is a load.
- i_ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- i_mem_req  in  1  MEM stage has an outstanding dmem access.
- i_mem_ready  in  1  dmem completes the access this cycle.
- o_stall_if, o_stall_id  out  1 each  hold PC / IF-ID register.
- o_stall_ex_mem  out  1  hold ID-EX, EX-MEM and MEM-WB registers.
- o_flush_id  out  1  clear IF-ID to a NOP.
- o_flush_ex  out  1  insert a bubble into ID-EX.
- o_state  out  2  current FSM state (debug).
- o_stall_cnt  out  32  stall-cycle count (present only with macro, REQ-020).

Function
REQ-003 SHALL implement FSM states RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2; 2'd3 is illegal and SHALL return to RUN on the next edge with all outputs deasserted.
REQ-004 SHALL compute load_use = i_ex_mem_read & (i_ex_rd != 0) & ((i_id_uses_rs1 & i_id_rs1 == i_ex_rd) | (i_id_uses_rs2 & i_id_rs2 == i_ex_rd)).
REQ-005 SHALL compute mem_stall = i_mem_req & ~i_mem_ready.
REQ-006 SHALL produce outputs combinationally from state and inputs, with zero latency from cause to control.
REQ-007 Priority SHALL be mem_stall > branch flush > load_use.
REQ-008 RUN, mem_stall: SHALL assert o_stall_if, o_stall_id and o_stall_ex_mem with no flush, and go to MEM_WAIT.
REQ-009 RUN, ~mem_stall & i_ex_branch_taken: SHALL assert o_flush_id and o_flush_ex for that cycle; if FLUSH_CYCLES>1, SHALL load the flush counter with FLUSH_CYCLES-1 and go to FLUSH.
REQ-010 RUN, load_use only: SHALL assert o_stall_if, o_stall_id and o_flush_ex for exactly that cycle and stay in RUN; the bubble clears load_use on the next cycle.
REQ-011 MEM_WAIT: SHALL keep all three stalls asserted while mem_stall; when i_mem_ready=1, SHALL deassert them that same cycle.
REQ-012 MEM_WAIT exit: with pending_flush=0, SHALL go to RUN; with pending_flush=1, SHALL assert o_flush_id and o_flush_ex that cycle, clear pending_flush, and apply the REQ-009 counter rule.
REQ-013 i_ex_branch_taken during mem_stall SHALL set the pending_flush flag; the branch SHALL never be dropped.
REQ-014 FLUSH: SHALL assert o_flush_id only, decrement the counter each cycle, and go to RUN when the counter reaches 1.
REQ-015 FLUSH: load_use SHALL be ignored.
REQ-016 FLUSH: mem_stall SHALL freeze the counter, assert all stalls, and suppress o_flush_id until the stall clears.
REQ-017 FLUSH: a new i_ex_branch_taken SHALL restart the flush (REQ-009).
REQ-018 o_flush_* and o_stall_* SHALL never both target the same pipeline register in one cycle, except o_flush_ex with o_stall_id under load-use.

Reset
REQ-019 While i_rst_n=0: state=RUN, flush counter=0, pending_flush=0, o_stall_cnt=0, and all control outputs=0; reset mid-MEM_WAIT or mid-FLUSH SHALL discard pending work.

Configuration
REQ-020 With HAZARD_PERF_CNT_EN defined, o_stall_cnt SHALL increment (wrapping at 2^32) every cycle o_stall_if=1. Without the macro, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 Load-use: EX lw x5, ID add x6,x5,x1 -> one cycle of stall_if=stall_id=flush_ex=1, then all outputs 0; with rd=x0 -> no stall.
REQ-022 Mem wait: mem_req=1, ready=0 for 3 cycles, then 1 -> stall_ex_mem=1 for 3 cycles, 0 on the ready cycle, state 1->0.
REQ-023 Branch: taken with FLUSH_CYCLES=2 -> cycle0 flush_id=flush_ex=1, cycle1 flush_id=1 only, cycle2 all outputs 0.
REQ-024 Branch during wait: branch_taken at wait cycle 1, ready at cycle 4 -> flush_id=flush_ex=1 at cycle 4, exactly once.
REQ-025 Reset mid-FLUSH: assert i_rst_n=0 asynchronously -> outputs 0 immediately, o_state=0.
REQ-026 Counter (macro on): 5 stall cycles -> o_stall_cnt=5; preset 32'hFFFFFFFF, one stall -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, memory-wait and branch-flush hazard control; HAZARD_PERF_CNT_EN adds o_stall_cnt
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_stall_if,
  output logic        o_stall_id,
  output logic        o_stall_ex_mem,
  output logic        o_flush_id,
  output logic        o_flush_ex,
  output logic [1:0]  o_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2;
  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit MULTI = FLUSH_CYCLES > 1;
  logic [1:0] state, nstate;
  logic [2:0] cnt, ncnt;
  logic pend, npend, load_use, mem_stall, br, legal, flush_all, lu_act;
  assign load_use = i_ex_mem_read & (i_ex_rd != 5'd0) &
                    ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) | (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
  assign mem_stall = i_mem_req & ~i_mem_ready;
  assign br = i_ex_branch_taken | pend;
  // state, flush counter and deferred-branch flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt <= 3'd0;
      pend <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      pend <= npend;
    end
  end
  // next state: memory wait freezes everything and defers branches; branches (re)load the flush counter
  always_comb begin
    nstate = RUN;
    ncnt = cnt;
    npend = pend;
    if (state == 2'd3) begin
      ncnt = 3'd0;
      npend = 1'b0;
    end else if (mem_stall) begin
      nstate = (state == RUN) ? MEM_WAIT : state;
      npend = br;
    end else if (br) begin
      nstate = MULTI ? FLUSH : RUN;
      ncnt = RELOAD;
      npend = 1'b0;
    end else if (state == FLUSH) begin
      nstate = (cnt == 3'd1) ? RUN : FLUSH;
      ncnt = cnt - 3'd1;
    end
  end
  // control outputs: mem_stall > branch flush > load_use, all forced low in reset or the illegal state
  always_comb begin
    legal = i_rst_n & (state != 2'd3);
    flush_all = legal & ~mem_stall & br;
    lu_act = legal & ~mem_stall & ~br & (state != FLUSH) & load_use;
    o_stall_ex_mem = legal & mem_stall;
    o_stall_if = o_stall_ex_mem | lu_act;
    o_stall_id = o_stall_if;
    o_flush_ex = flush_all | lu_act;
    o_flush_id = flush_all | (legal & ~mem_stall & (state == FLUSH));
    o_state = i_rst_n ? state : RUN;
  end
`ifdef HAZARD_PERF_CNT_EN
  // free-running count of IF stall cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_stall_cnt <= 32'd0;
    else if (o_stall_if) o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard control outputs and state
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, bt, req, rdy;
  logic sif, sid, sem, fid, fex;
  logic [1:0] st;
  int checks = 0, errors = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt;
`endif
  pipeline_hazard_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2), .i_ex_rd(rd), .i_ex_mem_read(mr),
    .i_ex_branch_taken(bt), .i_mem_req(req), .i_mem_ready(rdy),
    .o_stall_if(sif), .o_stall_id(sid), .o_stall_ex_mem(sem),
    .o_flush_id(fid), .o_flush_ex(fex), .o_state(st)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cnt(scnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; bt = 0; req = 0; rdy = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // exp = {stall_if, stall_id, stall_ex_mem, flush_id, flush_ex, state}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {sif, sid, sem, fid, fex, st};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  initial begin
    idle();
    rst_n = 1'b0;
    req = 1;
    chk("reset_outputs", 7'b0000000);
    #11 rst_n = 1'b1;
    idle();
    tick();
    chk("idle", 7'b0000000);
    rs1 = 5; u1 = 1; rs2 = 1; u2 = 1; rd = 5; mr = 1;
    chk("load_use_rs1", 7'b1100100);
    tick();
    mr = 0;
    chk("load_use_bubble", 7'b0000000);
    tick();
    rs1 = 0; rd = 0; mr = 1;
    chk("load_use_x0", 7'b0000000);
    rs1 = 3; rs2 = 7; rd = 7;
    chk("load_use_rs2", 7'b1100100);
    u2 = 0;
    chk("load_use_unused", 7'b0000000);
    idle();
    tick();
    req = 1;
    chk("mem_wait_c0", 7'b1110000);
    tick();
    chk("mem_wait_c1", 7'b1110001);
    tick();
    chk("mem_wait_c2", 7'b1110001);
    rdy = 1;
    chk("mem_wait_ready", 7'b0000001);
    tick();
    idle();
    chk("mem_wait_done", 7'b0000000);
    bt = 1;
    chk("branch_c0", 7'b0001100);
    tick();
    bt = 0;
    chk("branch_c1", 7'b0001010);
    tick();
    chk("branch_c2", 7'b0000000);
    req = 1;
    chk("bwait_c0", 7'b1110000);
    tick();
    bt = 1;
    chk("bwait_c1", 7'b1110001);
    tick();
    bt = 0;
    chk("bwait_c2", 7'b1110001);
    tick();
    chk("bwait_c3", 7'b1110001);
    tick();
    rdy = 1;
    chk("bwait_ready_flush", 7'b0001101);
    tick();
    idle();
    chk("bwait_flush_tail", 7'b0001010);
    tick();
    chk("bwait_done_once", 7'b0000000);
    bt = 1;
    tick();
    bt = 0; req = 1;
    chk("flush_mem_freeze_a", 7'b1110010);
    tick();
    chk("flush_mem_freeze_b", 7'b1110010);
    rdy = 1; rs1 = 9; u1 = 1; rd = 9; mr = 1;
    chk("flush_resume_ignore_lu", 7'b0001010);
    tick();
    idle();
    chk("flush_freeze_done", 7'b0000000);
    bt = 1;
    tick();
    chk("flush_restart", 7'b0001110);
    tick();
    bt = 0;
    chk("flush_restart_tail", 7'b0001010);
    tick();
    chk("flush_restart_done", 7'b0000000);
    bt = 1;
    tick();
    bt = 0;
    rst_n = 1'b0;
    chk("reset_mid_flush", 7'b0000000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_reset", 7'b0000000);
`ifdef HAZARD_PERF_CNT_EN
    req = 1;
    repeat (5) tick();
    idle();
    tick();
    checks++;
    assert (scnt === 32'd5) else begin
      errors++;
      $error("FAIL stall_cnt5 observed %0d expected 5", scnt);
    end
    force dut.o_stall_cnt = 32'hFFFFFFFF;
    #1 release dut.o_stall_cnt;
    req = 1;
    tick();
    idle();
    #1;
    checks++;
    assert (scnt === 32'd0) else begin
      errors++;
      $error("FAIL stall_cnt_wrap observed %h expected 0", scnt);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
